// File: rtl/oven_timer_if.sv
// Keypad/control and display bundle for the oven countdown timer.
// The master drives requests and reads the display; the slave is the timer.
interface oven_timer_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       start;
  logic       stop;
  logic       clear;
  logic       door_open;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       cooking;
  logic       done;

  modport master (
    output digit_valid, digit, start, stop, clear, door_open,
    input  min_tens, min_ones, sec_tens, sec_ones, cooking, done
  );

  modport slave (
    input  digit_valid, digit, start, stop, clear, door_open,
    output min_tens, min_ones, sec_tens, sec_ones, cooking, done
  );
endinterface

// File: rtl/oven_timer.sv
// MM:SS BCD oven countdown timer with keypad entry, pause on stop/door and a DONE state.
// Every output comes straight from a flop; there is no input-to-output combinational path.
module oven_timer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic         clk,
  input logic         rst_n,
  oven_timer_if.slave ctl
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StCook, StPause, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     time_q, time_d;  // {min_tens, min_ones, sec_tens, sec_ones}
  logic [CntW-1:0] tick_q, tick_d;
  logic            cooking_q, cooking_d;
  logic            done_q, done_d;
  logic [15:0]     time_dec;
  logic            tick;

  // BCD borrow chain; seconds 60-99 count down as entered.
  always_comb begin
    time_dec = time_q;
    if (time_q[3:0] != 4'd0) begin
      time_dec[3:0] = time_q[3:0] - 4'd1;
    end else begin
      time_dec[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) begin
        time_dec[7:4] = time_q[7:4] - 4'd1;
      end else begin
        time_dec[7:4] = 4'd5;
        if (time_q[11:8] != 4'd0) begin
          time_dec[11:8] = time_q[11:8] - 4'd1;
        end else begin
          time_dec[11:8]  = 4'd9;
          time_dec[15:12] = time_q[15:12] - 4'd1;
        end
      end
    end
  end

  assign tick = (tick_q == CntLast);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tick_d  = tick_q;
    if (ctl.clear) begin
      state_d = StIdle;
      time_d  = 16'h0000;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctl.start && !ctl.door_open && (time_q != 16'h0000)) begin
            state_d = StCook;
            tick_d  = '0;
          end else if (ctl.digit_valid && (ctl.digit <= 4'd9)) begin
            time_d = {time_q[11:0], ctl.digit};
          end
        end
        StCook: begin
          // A tick coinciding with a pause request is dropped and the count held.
          if (ctl.door_open || ctl.stop) begin
            state_d = StPause;
          end else if (tick) begin
            tick_d = '0;
            time_d = time_dec;
            if (time_q == 16'h0001) begin
              state_d = StDone;
            end
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
        StPause: begin
          if (ctl.start && !ctl.door_open) begin
            state_d = StCook;
          end
        end
        StDone: begin
          if (ctl.door_open) begin
            state_d = StIdle;
            time_d  = 16'h0000;
            tick_d  = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    cooking_d = (state_d == StCook);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      time_q    <= 16'h0000;
      tick_q    <= '0;
      cooking_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      tick_q    <= tick_d;
      cooking_q <= cooking_d;
      done_q    <= done_d;
    end
  end

  assign ctl.min_tens = time_q[15:12];
  assign ctl.min_ones = time_q[11:8];
  assign ctl.sec_tens = time_q[7:4];
  assign ctl.sec_ones = time_q[3:0];
  assign ctl.cooking  = cooking_q;
  assign ctl.done     = done_q;

endmodule

// File: tb/tb_oven_timer.sv
// Directed and randomized bench for oven_timer with TICK_DIV=4, checked against
// an arithmetic minutes/seconds model.
module tb_oven_timer;
  localparam int TD = 4;

  logic clk;
  logic rst_n;
  oven_timer_if bus ();

  oven_timer #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode 0 idle, 1 cook, 2 pause, 3 done; time kept as integer minutes and seconds.
  int m_mode, m_min, m_sec, m_cnt;
  logic door;

  function automatic void model_reset();
    m_mode = 0; m_min = 0; m_sec = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(bit dv, int d, bit st, bit sp, bit cl, bit dr);
    int v;
    if (cl) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: begin
        if (st && !dr && (m_min != 0 || m_sec != 0)) begin
          m_mode = 1; m_cnt = 0;
        end else if (dv && d <= 9) begin
          v = ((m_min * 100 + m_sec) * 10 + d) % 10000;
          m_min = v / 100; m_sec = v % 100;
        end
      end
      1: begin
        if (dr || sp) m_mode = 2;
        else if (m_cnt == TD - 1) begin
          m_cnt = 0;
          if (m_min == 0 && m_sec == 1) begin
            m_sec = 0; m_mode = 3;
          end else if (m_sec > 0) m_sec = m_sec - 1;
          else begin
            m_sec = 59; m_min = m_min - 1;
          end
        end else m_cnt = m_cnt + 1;
      end
      2: if (st && !dr) m_mode = 1;
      default: if (dr) model_reset();
    endcase
  endfunction

  function automatic logic [15:0] obs_digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  function automatic logic [15:0] model_digits();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".digits"}, obs_digits(), model_digits());
    check({tag, ".cooking"}, 16'(bus.cooking), 16'(m_mode == 1));
    check({tag, ".done"}, 16'(bus.done), 16'(m_mode == 3));
  endtask

  task automatic expect_out(input string tag, input logic [15:0] dig, input bit ck, input bit dn);
    check({tag, ".digits"}, obs_digits(), dig);
    check({tag, ".cooking"}, 16'(bus.cooking), 16'(ck));
    check({tag, ".done"}, 16'(bus.done), 16'(dn));
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next one.
  task automatic step(input bit dv, input int d, input bit st, input bit sp, input bit cl,
                      input string tag);
    bus.digit_valid = dv;
    bus.digit       = 4'(d);
    bus.start       = st;
    bus.stop        = sp;
    bus.clear       = cl;
    bus.door_open   = door;
    @(posedge clk);
    model_step(dv, d, st, sp, cl, door);
    #1;
    bus.digit_valid = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.clear       = 1'b0;
    check_model(tag);
  endtask

  task automatic key(input int d);
    step(1, d, 0, 0, 0, "key");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, "wait");
  endtask

  task automatic enter4(input int a, input int b, input int c, input int e);
    key(a); key(b); key(c); key(e);
  endtask

  initial begin
    door = 1'b0;
    bus.digit_valid = 1'b0; bus.digit = 4'd0; bus.start = 1'b0;
    bus.stop = 1'b0; bus.clear = 1'b0; bus.door_open = 1'b0;
    model_reset();
    rst_n = 1'b0;
    #2;
    expect_out("reset", 16'h0000, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Keys 1,3,0 then start; first decrement TD cycles after start.
    key(1); key(3); key(0);
    expect_out("entry130", 16'h0130, 0, 0);
    step(0, 0, 1, 0, 0, "start130");
    expect_out("cook130", 16'h0130, 1, 0);
    idle(TD - 1);
    expect_out("pretick", 16'h0130, 1, 0);
    idle(1);
    expect_out("tick129", 16'h0129, 1, 0);
    step(0, 0, 0, 0, 1, "clr");

    // 0001 -> DONE; start ignored; door returns to IDLE.
    enter4(0, 0, 0, 1);
    step(0, 0, 1, 0, 0, "start1");
    idle(TD);
    expect_out("done", 16'h0000, 0, 1);
    step(0, 0, 1, 0, 0, "done_start");
    expect_out("done_hold", 16'h0000, 0, 1);
    door = 1'b1;
    step(0, 0, 0, 0, 0, "done_door");
    expect_out("done_exit", 16'h0000, 0, 0);
    door = 1'b0;

    // 0100: stop at count 2, resume, minute borrow two cycles later.
    enter4(0, 1, 0, 0);
    step(0, 0, 1, 0, 0, "start100");
    idle(2);
    step(0, 0, 0, 1, 0, "stop");
    expect_out("paused", 16'h0100, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0, "resume");
    idle(1);
    expect_out("resume1", 16'h0100, 1, 0);
    idle(1);
    expect_out("borrow", 16'h0059, 1, 0);
    step(0, 0, 0, 0, 1, "clr2");

    // Door blocks start in IDLE; door on a tick pauses without decrement.
    enter4(0, 0, 0, 5);
    door = 1'b1;
    step(0, 0, 1, 0, 0, "door_start");
    expect_out("door_idle", 16'h0005, 0, 0);
    door = 1'b0;
    step(0, 0, 1, 0, 0, "start5");
    idle(TD - 1);
    door = 1'b1;
    step(0, 0, 0, 0, 0, "door_tick");
    expect_out("door_tick", 16'h0005, 0, 0);
    step(0, 0, 1, 0, 0, "door_resume");
    expect_out("door_noresume", 16'h0005, 0, 0);
    door = 1'b0;

    // Illegal digit, stop+start in COOK, clear+start in COOK.
    step(0, 0, 0, 0, 1, "clr3");
    enter4(0, 0, 9, 0);
    step(1, 12, 0, 0, 0, "digit12");
    expect_out("digit12", 16'h0090, 0, 0);
    step(0, 0, 1, 0, 0, "start90");
    idle(TD);
    expect_out("sec89", 16'h0089, 1, 0);
    step(0, 0, 1, 1, 0, "stop_start");
    expect_out("stop_start", 16'h0089, 0, 0);
    step(0, 0, 1, 0, 0, "resume90");
    step(0, 0, 1, 0, 1, "clear_start");
    expect_out("clear_start", 16'h0000, 0, 0);

    // Asynchronous reset mid-COOK between edges.
    enter4(0, 2, 0, 0);
    step(0, 0, 1, 0, 0, "start200");
    idle(TD + 2);
    #3 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 16'h0000, 0, 0);
    model_reset();
    #2 rst_n = 1'b1;
    idle(TD + 1);
    expect_out("post_rst", 16'h0000, 0, 0);
    key(7);
    expect_out("first_key", 16'h0007, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) door = ~door;
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 79) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/oven_timer.md
OVEN_TIMER -- requirements
Module: oven_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving clk cycles per countdown second; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port digit_valid, input, 1 bit, a one-cycle keypad strobe qualifying digit.
REQ-005 The block SHALL have port digit, input, 4 bits, the keypad value, where only 0-9 are accepted.
REQ-006 The block SHALL have port start, input, 1 bit, a one-cycle start request.
REQ-007 The block SHALL have port stop, input, 1 bit, a one-cycle pause request.
REQ-008 The block SHALL have port clear, input, 1 bit, a one-cycle cancel/clear request.
REQ-009 The block SHALL have port door_open, input, 1 bit, a level that is 1 while the door is open.
REQ-010 The block SHALL have ports min_tens, min_ones, sec_tens and sec_ones, each an output of 4 bits, holding BCD display digits that feed the seven-segment decoders.
REQ-011 The block SHALL have port cooking, output, 1 bit, which is 1 only in COOK.
REQ-012 The block SHALL have port done, output, 1 bit, which is 1 only in DONE.

Function
REQ-013 The block SHALL implement four states: IDLE, COOK, PAUSE and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, digit_valid with digit<=9 SHALL shift the time left one digit: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
REQ-015 Digits 10-15, and digit_valid outside IDLE, SHALL be ignored with no state or digit change.
REQ-016 In IDLE, start with door_open=0 and a non-zero time SHALL enter COOK and zero the tick counter; start with time 0000 or door_open=1 SHALL be ignored.
REQ-017 In COOK, the tick counter SHALL count 0..TICK_DIV-1; the cycle where it equals TICK_DIV-1 is a tick, and the counter SHALL then wrap to 0.
REQ-018 The first decrement SHALL therefore occur exactly TICK_DIV cycles after the start edge.
REQ-019 On a tick, the time SHALL decrement as BCD MM:SS using these borrow rules:
- sec_ones>0: decrement sec_ones.
- Otherwise sec_ones=9, and if sec_tens>0, decrement sec_tens.
- Otherwise sec_tens=5, and borrow from min_ones.
- If min_ones=0, min_ones=9 and min_tens is decremented.
REQ-020 Entered seconds of 60-99 SHALL be counted down as entered, with no normalisation (e.g. 0090 -> 0089).
REQ-021 A tick on which the time is 0001 SHALL load 0000 and enter DONE in the same cycle.
REQ-022 In COOK, stop or door_open=1 SHALL enter PAUSE with the tick counter held; a tick coinciding with either SHALL be discarded (no decrement).
REQ-023 In PAUSE, start with door_open=0 SHALL return to COOK and resume the held tick count.
REQ-024 In PAUSE, start with door_open=1 SHALL be ignored.
REQ-025 clear in any state SHALL load 0000, zero the tick counter and enter IDLE.
REQ-026 In DONE, door_open=1 SHALL also load 0000 and enter IDLE; start, stop and digit_valid SHALL be ignored.
REQ-027 When several requests occur in one cycle, priority SHALL be: clear > door_open > stop > start > digit_valid.
REQ-028 In COOK, stop and start together SHALL give PAUSE.
REQ-029 The block SHALL have no combinational path from any input to any output.

Reset
REQ-030 While rst_n=0, the block SHALL force state IDLE, all four digits 0, tick counter 0, cooking=0 and done=0, immediately and without a clock edge.
REQ-031 Reset asserted mid-COOK SHALL abandon the cook with no pending decrement.
REQ-032 After rst_n rises, the block SHALL accept digit_valid on the first clock edge.

Verification (TICK_DIV=4)
REQ-033 Enter keys 1,3,0 then start -> digits read 0,1,3,0; cooking=1; 4 cycles later digits read 0,1,2,9.
REQ-034 Enter 0,0,0,1 (0001) and start -> on the 4th cycle digits read 0000, done=1 and cooking=0; a following start leaves done=1; door_open=1 then gives IDLE with done=0.
REQ-035 Enter 0100, start, and assert stop at tick counter 2 -> PAUSE with 0100 held; start resumes and the first decrement (to 0059) occurs 2 cycles later; 0100 -> 0059 checks the minute borrow.
REQ-036 Assert door_open while in IDLE with time 0005 and pulse start -> stays IDLE; assert door_open on a tick cycle in COOK -> PAUSE with no decrement.
REQ-037 Present digit=12 with digit_valid -> digits unchanged; present clear and start in the same cycle during COOK -> IDLE with 0000.
REQ-038 Drop rst_n between clock edges mid-COOK -> outputs read 0000/0/0 before the next edge.
